// File: rtl/tgt_regf_arbiter_if.sv
// Bus bundle between the three engines, the register file and tgt_regf_arbiter.
//   slave  : arbiter view (requests, strobes, regf read data in; grant, regf port,
//            read return and timeout out)
//   master : requester / register-file side of the same signals
// Per-requester fields are packed: requester k uses [k*W +: W].
interface tgt_regf_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic [2:0]          i_req;
  logic [2:0]          i_wr_en;
  logic [2:0]          i_rd_en;
  logic [3*ADDR_W-1:0] i_addr;
  logic [3*DATA_W-1:0] i_wdata;
  logic [DATA_W-1:0]   i_regf_rdata;
  logic [2:0]          o_gnt;
  logic                o_regf_wr_en;
  logic                o_regf_rd_en;
  logic [ADDR_W-1:0]   o_regf_addr;
  logic [DATA_W-1:0]   o_regf_wdata;
  logic [DATA_W-1:0]   o_rdata;
  logic [2:0]          o_rd_valid;
  logic                o_timeout;

  modport slave (
    input  i_req, i_wr_en, i_rd_en, i_addr, i_wdata, i_regf_rdata,
    output o_gnt, o_regf_wr_en, o_regf_rd_en, o_regf_addr, o_regf_wdata,
           o_rdata, o_rd_valid, o_timeout
  );

  modport master (
    output i_req, i_wr_en, i_rd_en, i_addr, i_wdata, i_regf_rdata,
    input  o_gnt, o_regf_wr_en, o_regf_rd_en, o_regf_addr, o_regf_wdata,
           o_rdata, o_rd_valid, o_timeout
  );
endinterface

// File: rtl/tgt_regf_arbiter.sv
// tgt_regf_arbiter: round-robin owner of the target's single register-file port,
// shared by SDR (0), HDR-DDR normal transactions (1) and HDR CCC (2).
// Ports:
//   i_sys_clk : system clock, rising edge
//   i_sys_rst : asynchronous active-low reset
//   bus       : tgt_regf_arbiter_if.slave (requests/strobes/addr/wdata per engine,
//               regf read data in; one-hot grant, muxed regf port, read data,
//               per-requester read-valid and timeout pulse out)
// Optional feature macro: REGF_ARB_TIMEOUT_EN -- revokes a grant held MAX_HOLD
// cycles and masks the revoked engine until it drops its request.
module tgt_regf_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 64
) (
  input  logic                i_sys_clk,
  input  logic                i_sys_rst,
  tgt_regf_arbiter_if.slave   bus
);

  if ((MAX_HOLD < 1) || (MAX_HOLD > 255)) begin : g_hold_range
    $error("MAX_HOLD must be within 1..255");
  end

  typedef enum logic {IDLE, OWNED} state_t;

  state_t              state_q, state_d;
  logic [2:0]          gnt_q, gnt_d;
  logic [1:0]          last_q, last_d;
  logic [2:0]          rd_valid_q, rd_valid_d;

  logic                owner_req;
  logic                revoke;
  logic [2:0]          mask;
  logic [2:0]          eligible;
  logic                found;
  logic [1:0]          win;

  logic                regf_wr;
  logic                regf_rd;
  logic [ADDR_W-1:0]   regf_addr;
  logic [DATA_W-1:0]   regf_wdata;

  // Requester index 'off' positions after 'last', wrapping 2 -> 0.
  function automatic logic [1:0] rr_idx(input logic [1:0] last, input int unsigned off);
    int unsigned s;
    s = (32'(last) + off) % 3;
    return s[1:0];
  endfunction

  assign owner_req = |(bus.i_req & gnt_q);
  // On a forced revoke the current owner is excluded from the same-cycle search.
  assign eligible  = bus.i_req & ~mask & (revoke ? ~gnt_q : 3'b111);

  // State register
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      last_q     <= 2'd2;
      rd_valid_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Next-state: arbitrate when idle, when the owner releases, or on revoke
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    found   = 1'b0;
    win     = last_q;
    for (int unsigned off = 1; off <= 3; off++) begin
      if (!found && eligible[rr_idx(last_q, off)]) begin
        found = 1'b1;
        win   = rr_idx(last_q, off);
      end
    end
    if ((state_q == IDLE) || !owner_req || revoke) begin
      if (found) begin
        state_d = OWNED;
        gnt_d   = 3'b001 << win;
        last_d  = win;
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    end
  end

  // Outputs: owner's strobes onto the regf port; write beats read on collision
  always_comb begin
    regf_wr    = 1'b0;
    regf_rd    = 1'b0;
    regf_addr  = '0;
    regf_wdata = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      if (gnt_q[k]) begin
        regf_wr    = bus.i_wr_en[k];
        regf_rd    = bus.i_rd_en[k] & ~bus.i_wr_en[k];
        regf_addr  = bus.i_addr[k*ADDR_W +: ADDR_W];
        regf_wdata = bus.i_wdata[k*DATA_W +: DATA_W];
      end
    end
    // The issuing owner travels with the read, so a handoff cannot misroute it.
    rd_valid_d = gnt_q & {3{regf_rd}};
  end

`ifdef REGF_ARB_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;
  logic [2:0] mask_q, mask_d;
  logic       timeout_q;

  // hold_q counts completed cycles of the current grant, so the MAX_HOLD-th
  // owned cycle is the one that sees hold_q == MAX_HOLD-1.
  assign revoke = (state_q == OWNED) && owner_req && (hold_q == 8'(MAX_HOLD - 1));

  always_comb begin
    hold_d = '0;
    if ((state_q == OWNED) && (state_d == OWNED) && (gnt_d == gnt_q))
      hold_d = hold_q + 8'd1;
    mask_d = (mask_q & bus.i_req) | (revoke ? gnt_q : 3'b000);
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      hold_q    <= '0;
      mask_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      mask_q    <= mask_d;
      timeout_q <= revoke;
    end
  end

  assign mask          = mask_q;
  assign bus.o_timeout = timeout_q;
`else
  assign revoke        = 1'b0;
  assign mask          = '0;
  assign bus.o_timeout = 1'b0;
`endif

  assign bus.o_gnt        = gnt_q;
  assign bus.o_regf_wr_en = regf_wr;
  assign bus.o_regf_rd_en = regf_rd;
  assign bus.o_regf_addr  = regf_addr;
  assign bus.o_regf_wdata = regf_wdata;
  assign bus.o_rdata      = bus.i_regf_rdata;
  assign bus.o_rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_tgt_regf_arbiter.sv
// Scoreboard bench for tgt_regf_arbiter: stimulus pushes expected grant changes,
// regf accesses, read returns and timeout pulses (each tagged with its cycle);
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_tgt_regf_arbiter;
  localparam int AW = 10;
  localparam int DW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tgt_regf_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  tgt_regf_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(4)) dut (
    .i_sys_clk (clk),
    .i_sys_rst (rst_n),
    .bus       (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register-file model: unwritten locations read as addr[7:0] ^ 8'h3C
  logic [7:0]    mem [1024];
  logic [1023:0] written;
  always @(posedge clk) begin
    if (!rst_n) begin
      written <= '0;
    end else begin
      if (bus.o_regf_wr_en) begin
        mem[bus.o_regf_addr]     <= bus.o_regf_wdata;
        written[bus.o_regf_addr] <= 1'b1;
      end
      if (bus.o_regf_rd_en)
        bus.i_regf_rdata <= written[bus.o_regf_addr] ? mem[bus.o_regf_addr]
                                                     : (bus.o_regf_addr[7:0] ^ 8'h3C);
    end
  end

  typedef struct {
    int          cyc;
    int unsigned val;
  } ev_t;

  ev_t q_gnt[$];
  ev_t q_acc[$];
  ev_t q_rv[$];
  ev_t q_to[$];

  int checks   = 0;
  int failures = 0;

  function automatic void exp_gnt(logic [2:0] g, int d);
    q_gnt.push_back('{cyc + d, 32'(g)});
  endfunction
  function automatic void exp_acc(logic wr, logic rd, logic [AW-1:0] a, logic [DW-1:0] v);
    q_acc.push_back('{cyc, 32'({wr, rd, a, v})});
  endfunction
  function automatic void exp_rv(logic [2:0] m, logic [DW-1:0] v);
    q_rv.push_back('{cyc + 1, 32'({m, v})});
  endfunction
  function automatic void exp_to(int d);
    q_to.push_back('{cyc + d, 32'd1});
  endfunction

  function automatic void cmp_ev(string name, ev_t e, int unsigned act);
    checks++;
    if (e.cyc != cyc || e.val != act) begin
      failures++;
      $display("FAIL %s: got 0x%0h at cycle %0d, required 0x%0h at cycle %0d",
               name, act, cyc, e.val, e.cyc);
    end
  endfunction

  function automatic void unexp(string name, int unsigned act);
    checks++;
    failures++;
    $display("FAIL %s: unexpected event 0x%0h at cycle %0d, required none", name, act, cyc);
  endfunction

  function automatic void chk(string name, int unsigned act, int unsigned req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endfunction

  // Monitor
  logic [2:0] prev_gnt = 3'b000;
  always @(negedge clk) begin
    ev_t e;
    if (bus.o_gnt !== prev_gnt) begin
      if (q_gnt.size() == 0) unexp("gnt", 32'(bus.o_gnt));
      else begin e = q_gnt.pop_front(); cmp_ev("gnt", e, 32'(bus.o_gnt)); end
      prev_gnt = bus.o_gnt;
    end
    if (bus.o_regf_wr_en || bus.o_regf_rd_en) begin
      if (q_acc.size() == 0)
        unexp("regf_access", 32'({bus.o_regf_wr_en, bus.o_regf_rd_en, bus.o_regf_addr, bus.o_regf_wdata}));
      else begin
        e = q_acc.pop_front();
        cmp_ev("regf_access", e, 32'({bus.o_regf_wr_en, bus.o_regf_rd_en, bus.o_regf_addr, bus.o_regf_wdata}));
      end
    end
    if (bus.o_rd_valid != 3'b000) begin
      if (q_rv.size() == 0) unexp("rd_valid", 32'({bus.o_rd_valid, bus.o_rdata}));
      else begin e = q_rv.pop_front(); cmp_ev("rd_valid", e, 32'({bus.o_rd_valid, bus.o_rdata})); end
    end
    if (bus.o_timeout) begin
      if (q_to.size() == 0) unexp("timeout", 32'd1);
      else begin e = q_to.pop_front(); cmp_ev("timeout", e, 32'd1); end
    end
    if (bus.o_gnt == 3'b000)
      chk("idle_regf_zero", 32'({bus.o_regf_wr_en, bus.o_regf_rd_en, bus.o_regf_addr, bus.o_regf_wdata}), 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int k, logic wr, logic rd, logic [AW-1:0] a, logic [DW-1:0] v);
    bus.i_wr_en[k]           = wr;
    bus.i_rd_en[k]           = rd;
    bus.i_addr[k*AW +: AW]   = a;
    bus.i_wdata[k*DW +: DW]  = v;
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_gnt"},      32'(bus.o_gnt), 0);
    chk({tag, "_rd_valid"}, 32'(bus.o_rd_valid), 0);
    chk({tag, "_timeout"},  32'(bus.o_timeout), 0);
    chk({tag, "_regf"},     32'({bus.o_regf_wr_en, bus.o_regf_rd_en, bus.o_regf_addr, bus.o_regf_wdata}), 0);
  endtask

  logic [7:0] burst_exp [4] = '{8'h34, 8'h35, 8'h36, 8'h37};

  initial begin
    bus.i_req   = '0;
    bus.i_wr_en = '0;
    bus.i_rd_en = '0;
    bus.i_addr  = '0;
    bus.i_wdata = '0;
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    // Round robin: all request, each owner releases after two grant cycles
    bus.i_req = 3'b111; exp_gnt(3'b001, 1); tick();
    tick();
    bus.i_req = 3'b110; exp_gnt(3'b010, 1); tick();
    bus.i_req = 3'b111; tick();
    bus.i_req = 3'b101; exp_gnt(3'b100, 1); tick();
    tick();
    bus.i_req = 3'b001; exp_gnt(3'b001, 1); tick();
    tick();
    bus.i_req = 3'b000; exp_gnt(3'b000, 1); tick();
    tick();

    // Single write by the NT engine
    bus.i_req = 3'b010; exp_gnt(3'b010, 1); tick();
    drive(1, 1'b1, 1'b0, 10'd1000, 8'hA5); exp_acc(1'b1, 1'b0, 10'd1000, 8'hA5); tick();
    drive(1, 1'b0, 1'b0, '0, '0); bus.i_req = 3'b000; exp_gnt(3'b000, 1); tick();
    tick();

    // Burst atomicity: CCC engine reads 8..11 while SDR waits
    bus.i_req = 3'b101; exp_gnt(3'b100, 1); tick();
    for (int i = 0; i < 4; i++) begin
      drive(2, 1'b0, 1'b1, 10'(8 + i), 8'h00);
      exp_acc(1'b0, 1'b1, 10'(8 + i), 8'h00);
      exp_rv(3'b100, burst_exp[i]);
      tick();
    end
    drive(2, 1'b0, 1'b0, '0, '0); bus.i_req = 3'b001; exp_gnt(3'b001, 1); tick();

    // Collision (write wins) with non-owner strobes active
    drive(0, 1'b1, 1'b1, 10'h155, 8'h3E);
    drive(1, 1'b1, 1'b0, 10'h2AA, 8'hC3);
    drive(2, 1'b0, 1'b1, 10'h0F0, 8'h77);
    exp_acc(1'b1, 1'b0, 10'h155, 8'h3E); tick();
    drive(0, 1'b0, 1'b0, 10'h155, 8'h3E); tick();
    drive(1, 1'b0, 1'b0, '0, '0);
    drive(2, 1'b0, 1'b0, '0, '0);
    drive(0, 1'b0, 1'b1, 10'h155, 8'h00);
    exp_acc(1'b0, 1'b1, 10'h155, 8'h00); exp_rv(3'b001, 8'h3E); tick();

    // Reset lands before the read return of this access
    drive(0, 1'b0, 1'b1, 10'h200, 8'h00); exp_acc(1'b0, 1'b1, 10'h200, 8'h00);
    #7;
    rst_n = 1'b0; exp_gnt(3'b000, 1);
    #1;
    check_all_zero("rst_mid_read");
    drive(0, 1'b0, 1'b0, '0, '0);
    repeat (2) tick();
    rst_n = 1'b1; bus.i_req = 3'b111; exp_gnt(3'b001, 1); tick();
    bus.i_req = 3'b000; exp_gnt(3'b000, 1); tick();
    tick();

`ifdef REGF_ARB_TIMEOUT_EN
    // Timeout: requester 1 holds past MAX_HOLD=4 while requester 0 waits
    bus.i_req = 3'b011; exp_gnt(3'b010, 1); exp_gnt(3'b001, 5); exp_to(5);
    repeat (6) tick();
    bus.i_req = 3'b010; exp_gnt(3'b000, 1);
    repeat (3) tick();
    bus.i_req = 3'b000; tick();
    bus.i_req = 3'b010; exp_gnt(3'b010, 1); tick();
    bus.i_req = 3'b000; exp_gnt(3'b000, 1); tick();
`endif

    repeat (4) tick();
    chk("pending_gnt", q_gnt.size(), 0);
    chk("pending_acc", q_acc.size(), 0);
    chk("pending_rd_valid", q_rv.size(), 0);
    chk("pending_timeout", q_to.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
